// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer
// Walks every pixel of one frame in raster order on a start pulse. For each
// coordinate it presents x/y to a combinational renderer, captures the
// returned colour, and streams a RAM-write command byte followed by two
// bytes per pixel (high byte first) to the LCD bus writer.
//
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   start              - frame request pulse, honoured only in IDLE
//   cube_state_in      - live cube state; snapshotted when a frame starts
//   cube_state_out     - frame snapshot held for the renderer
//   x, y               - current pixel coordinate to the renderer
//   pixel              - renderer colour for (x, y), same cycle
//   byte_data/byte_dc  - outgoing byte; dc=0 command, dc=1 pixel data
//   byte_valid/ready   - byte handshake
//   busy               - high whenever not IDLE
//   frame_done         - one-cycle pulse after the last byte transfers
//   state_dbg          - current FSM state
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
// Once byte_valid is raised, byte_valid, byte_data and byte_dc hold until that
// transfer happens (only reset can withdraw them).

module lcd_frame_streamer #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter logic [7:0]  CMD_RAMWR = 8'h2C
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [143:0]   cube_state_in,
  output logic [143:0]   cube_state_out,
  output logic [8:0]     x,
  output logic [7:0]     y,
  input  logic [15:0]    pixel,
  output logic [7:0]     byte_data,
  output logic           byte_dc,
  output logic           byte_valid,
  input  logic           byte_ready,
  output logic           busy,
  output logic           frame_done,
  output logic [2:0]     state_dbg
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_HI    = 3'd3;
  localparam logic [2:0] ST_LO    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [8:0] X_LAST = 9'(H_RES - 1);
  localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

  logic [2:0]   state_q, state_d;
  logic [8:0]   x_q, x_d;
  logic [7:0]   y_q, y_d;
  logic [143:0] cube_q, cube_d;
  logic [15:0]  pix_q, pix_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cube_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cube_q  <= cube_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cube_d  = cube_q;
    pix_d   = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cube_d  = cube_state_in;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (byte_ready) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Colour is frozen here so later renderer changes cannot alter the bytes.
        pix_d   = pixel;
        state_d = ST_HI;
      end
      ST_HI: begin
        if (byte_ready) state_d = ST_LO;
      end
      ST_LO: begin
        if (byte_ready) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = ST_DONE;
          end else if (x_q == X_LAST) begin
            x_d     = '0;
            y_d     = y_q + 8'd1;
            state_d = ST_FETCH;
          end else begin
            x_d     = x_q + 9'd1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Byte outputs decode from registered state and the captured colour only,
  // so they are naturally stable while a transfer is stalled.
  always_comb begin
    byte_valid = 1'b0;
    byte_dc    = 1'b0;
    byte_data  = 8'h00;
    case (state_q)
      ST_CMD: begin
        byte_valid = 1'b1;
        byte_data  = CMD_RAMWR;
      end
      ST_HI: begin
        byte_valid = 1'b1;
        byte_dc    = 1'b1;
        byte_data  = pix_q[15:8];
      end
      ST_LO: begin
        byte_valid = 1'b1;
        byte_dc    = 1'b1;
        byte_data  = pix_q[7:0];
      end
      default: begin
        byte_valid = 1'b0;
      end
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_DONE);
  assign x              = x_q;
  assign y              = y_q;
  assign cube_state_out = cube_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
module tb_lcd_frame_streamer;

  localparam int H = 4;
  localparam int V = 2;
  localparam logic [2:0] ST_HI = 3'd3;

  logic         clock;
  logic         reset;
  logic         start;
  logic [143:0] cube_state_in;
  logic [143:0] cube_state_out;
  logic [8:0]   x;
  logic [7:0]   y;
  logic [15:0]  pixel;
  logic [7:0]   byte_data;
  logic         byte_dc;
  logic         byte_valid;
  logic         byte_ready;
  logic         busy;
  logic         frame_done;
  logic [2:0]   state_dbg;

  int n_checks;
  int n_fail;
  logic [8:0]   exp_q[$];
  logic [143:0] snap;

  lcd_frame_streamer #(.H_RES(H), .V_RES(V), .CMD_RAMWR(8'h2C)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cube_state_in(cube_state_in), .cube_state_out(cube_state_out),
    .x(x), .y(y), .pixel(pixel),
    .byte_data(byte_data), .byte_dc(byte_dc), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Renderer model: high byte = x, low byte = y. While a byte is being
  // offered the colour is scrambled, so only a colour captured in FETCH is right.
  assign pixel = {x[7:0], y} ^ (byte_valid ? 16'hA5A5 : 16'h0000);

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver: pulse start for one edge and push the expected frame bytes.
  task automatic start_frame(input logic [143:0] cube);
    start = 1'b1;
    cube_state_in = cube;
    exp_q.push_back({1'b0, 8'h2C});
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        exp_q.push_back({1'b1, 8'(xx)});
        exp_q.push_back({1'b1, 8'(yy)});
      end
    end
    tick();
    start = 1'b0;
    snap = cube;
    check("start_cmd_valid", {143'b0, byte_valid}, 144'd1);
    check("start_cmd_busy", {143'b0, busy}, 144'd1);
    check("start_snapshot", cube_state_out, cube);
  endtask

  // Runs the frame currently in flight, popping the scoreboard on each transfer.
  task automatic run_frame(input bit rand_ready, input bit disturb, input bit abort_hi21);
    int c;
    bit done;
    bit prev_stall;
    logic [8:0] prev_byte;
    logic [8:0] got;
    c = 1;
    done = 0;
    prev_stall = 0;
    prev_byte = '0;
    while (!done && c < 2000) begin
      if (c % 4 == 1) check("snapshot_hold", cube_state_out, snap);
      if (prev_stall) begin
        check("stall_valid", {143'b0, byte_valid}, 144'd1);
        check("stall_byte", {135'b0, byte_dc, byte_data}, {135'b0, prev_byte});
      end
      if (x >= 9'(H) || y >= 8'(V)) check("xy_range", {127'b0, x, y}, 144'd0);
      if (abort_hi21 && state_dbg == ST_HI && x == 9'd2 && y == 8'd1) begin
        reset = 1'b1;
        byte_ready = 1'b0;
        tick();
        reset = 1'b0;
        check("abort_busy", {143'b0, busy}, 144'd0);
        check("abort_valid", {143'b0, byte_valid}, 144'd0);
        check("abort_xy", {127'b0, x, y}, 144'd0);
        check("abort_cube", cube_state_out, 144'd0);
        exp_q.delete();
        return;
      end
      if (frame_done) begin
        done = 1;
        if (!rand_ready) check("done_cycle", 144'(c), 144'd26);
        check("queue_empty", 144'(exp_q.size()), 144'd0);
      end else begin
        check("busy_in_frame", {143'b0, busy}, 144'd1);
        byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (disturb && c == 10) begin
          start = 1'b1;
          cube_state_in = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        end else begin
          start = 1'b0;
        end
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {135'b0, byte_dc, byte_data}, 144'h1ff000);
          end else begin
            got = exp_q.pop_front();
            check("byte", {135'b0, byte_dc, byte_data}, {135'b0, got});
          end
        end
        prev_stall = byte_valid && !byte_ready;
        prev_byte = {byte_dc, byte_data};
        tick();
        c++;
      end
    end
    if (!done) check("frame_timeout", 144'(c), 144'd0);
    // A start held during DONE must be ignored.
    start = 1'b1;
    cube_state_in = ~snap;
    tick();
    start = 1'b0;
    check("post_done_idle", {142'b0, busy, frame_done}, 144'd0);
    check("post_done_snapshot", cube_state_out, snap);
    tick();
    tick();
    check("no_queued_start", {143'b0, busy}, 144'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    cube_state_in = '0;
    byte_ready = 1'b0;
    snap = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      byte_ready = 1'($urandom_range(0, 1));
      check("idle_valid", {143'b0, byte_valid}, 144'd0);
      check("idle_busy", {143'b0, busy}, 144'd0);
      tick();
    end
    check("reset_xy", {127'b0, x, y}, 144'd0);
    check("reset_byte", {134'b0, byte_valid, byte_dc, byte_data}, 144'd0);
    check("reset_done", {143'b0, frame_done}, 144'd0);
    check("reset_cube", cube_state_out, 144'd0);

    // Always-ready frame with a mid-frame start and cube edit.
    start_frame({16'hBEEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210});
    run_frame(1'b0, 1'b1, 1'b0);

    // Random back-pressure frame.
    start_frame({$urandom, $urandom, $urandom, $urandom, 16'($urandom)});
    run_frame(1'b1, 1'b0, 1'b0);

    // Reset in HI of pixel (2,1), then a full clean frame.
    start_frame({144{1'b1}});
    run_frame(1'b0, 1'b0, 1'b1);
    tick();
    start_frame({72'h5A5A_5A5A_5A5A_5A5A_5A, 72'hC3C3_C3C3_C3C3_C3C3_C3});
    run_frame(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_frame_streamer.md
# lcd_frame_streamer

Raster scanner and byte-stream source for the cube display path. On a start pulse it snapshots the cube state and walks every pixel coordinate in raster order. For each coordinate it drives `x`/`y` to the combinational cube-state renderer and captures the returned 16-bit colour. It then emits a RAM-write command byte followed by the captured colours, two bytes per pixel, over a valid/ready byte interface to the LCD bus writer.

## Interface
Parameters:
- `H_RES`, 320, pixels per line; `x` counts 0..H_RES-1
- `V_RES`, 240, lines per frame; `y` counts 0..V_RES-1
- `CMD_RAMWR`, 8'h2C, command byte sent at the start of each frame

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  frame request pulse; sampled only in IDLE
- `cube_state_in`  in  144  live cube state from the input logic
- `cube_state_out`  out  144  frame snapshot fed to the renderer
- `x`  out  9  current pixel column to the renderer
- `y`  out  8  current pixel row to the renderer
- `pixel`  in  16  renderer colour for (`x`,`y`), combinational, valid the same cycle
- `byte_data`  out  8  byte to the LCD writer
- `byte_dc`  out  1  0 = command byte, 1 = pixel data byte
- `byte_valid`  out  1  `byte_data`/`byte_dc` are valid
- `byte_ready`  in  1  writer accepts; a byte transfers on an edge where `byte_valid && byte_ready`
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame transfers

## Operation
- States: IDLE, CMD, FETCH, HI, LO, DONE.
- IDLE:
  - `start`=1 latches `cube_state_in` into `cube_state_out`, clears x=0, y=0 and moves to CMD.
  - Otherwise the block stays in IDLE.
- CMD: drives `byte_valid`=1, `byte_dc`=0, `byte_data`=CMD_RAMWR. On handshake it moves to FETCH.
- FETCH: `byte_valid`=0. Registers `pixel` into an internal 16-bit pixel register, then moves to HI unconditionally.
- HI: drives `byte_valid`=1, `byte_dc`=1, `byte_data`=pixreg[15:8]. On handshake it moves to LO.
- LO: drives `byte_valid`=1, `byte_dc`=1, `byte_data`=pixreg[7:0]. On handshake:
  - If x=H_RES-1 and y=V_RES-1, move to DONE.
  - Else if x=H_RES-1, set x=0, y=y+1 and move to FETCH.
  - Else set x=x+1 and move to FETCH.
- DONE: `frame_done`=1 for this one cycle, then IDLE. `x`/`y` hold their final values.
- `x`/`y` change only on the LO handshake, or when start is accepted. The values are therefore stable from FETCH through the end of LO.
- `cube_state_out` changes only when start is accepted, so a frame never tears on mid-frame state edits.
- While `byte_valid`=1 and `byte_ready`=0:
  - `byte_data` and `byte_dc` hold constant.
  - `byte_valid` never deasserts without a handshake.
- `start` is ignored in every state except IDLE, including DONE; there is no queued request.
- Arithmetic: the x/y counters never exceed H_RES-1/V_RES-1. Wrap is explicit, never a natural overflow.

## Timing
- Reset values:
  - Outputs: state IDLE, `x`=0, `y`=0, `cube_state_out`=0, `byte_data`=0, `byte_dc`=0, `byte_valid`=0, `busy`=0, `frame_done`=0.
  - Internal: pixreg=0.
- Reset asserted mid-frame returns the block to IDLE on the next edge. `byte_valid` drops with no handshake, which is acceptable because the LCD writer shares the reset.
- Start latency: `start` sampled at edge N → CMD with `byte_valid`=1 and `busy`=1 from cycle N+1.
- With `byte_ready` held high:
  - CMD takes 1 cycle; each pixel takes 3 cycles (FETCH, HI, LO).
  - A full frame is 1 + 3·H_RES·V_RES = 230401 cycles from CMD entry to DONE entry.
  - `frame_done` is high on cycle N+230402; `busy` is low from cycle N+230403.
- Each cycle of `byte_ready` low extends the current state by one cycle. No byte is lost or duplicated.
- Pixel capture: the colour transmitted is the `pixel` value present during FETCH. Later changes to `pixel` do not affect the bytes.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values, `busy`=0, no `byte_valid`.
- H_RES=4, V_RES=2, `byte_ready`=1, renderer model `pixel`={7'b0,x}<<8 | y → bytes 2C(dc0), then 00 00, 01 00, 02 00, 03 00, 00 01, 01 01, 02 01, 03 01; `frame_done` pulses on cycle N+26.
- Default parameters, `byte_ready`=1 → exactly 153601 transfers (1 command + 153600 data); last pair is for x=319, y=239; `frame_done` on cycle N+230402.
- Random `byte_ready` with 50% duty and H_RES=4, V_RES=2 → byte sequence identical to the always-ready run; `byte_data`/`byte_dc` stable whenever valid&&!ready.
- Change `cube_state_in` and pulse `start` again mid-frame → `cube_state_out` unchanged until IDLE; a second frame starts only from a start pulse issued after `frame_done`.
- Assert `reset` during HI of pixel (2,1) → next cycle IDLE, `byte_valid`=0, x=0, y=0; a following `start` produces a full, correct frame.
